seq_chunk_adder: RTL

- Parametrised multi-cycle adder/subtractor that replaces the fixed 4-bit ripple-carry adder where wide operands are needed.
- It processes CHUNK bits per clock through a CHUNK-bit ripple slice and keeps the carry in a register between chunks.
- A WIDTH-bit add therefore takes WIDTH/CHUNK cycles.
- Valid/ready handshakes on input and output let it sit between pipelined datapath stages.
- It also adds a subtract mode and signed-overflow detection.

---
 rtl/seq_chunk_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operation is computed CHUNK bits per
// clock through a small ripple slice, with valid/ready handshakes on both sides.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int N    = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_chunk_adder: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  op_a_reg, op_a_next;
  logic [WIDTH-1:0]  op_b_reg, op_b_next;
  logic [WIDTH-1:0]  s_reg, s_next;
  logic              carry_reg, carry_next;
  logic              cout_reg, cout_next;
  logic              cmsb_reg, cmsb_next;
  logic [IDXW-1:0]   idx_reg, idx_next;

  logic [31:0]       base;
  logic [CHUNK-1:0]  slice_a, slice_b, slice_sum;
  logic [CHUNK:0]    slice_c;
  logic              last_chunk;

  assign base       = 32'(idx_reg) * 32'(CHUNK);
  assign slice_a    = op_a_reg[base +: CHUNK];
  assign slice_b    = op_b_reg[base +: CHUNK];
  assign last_chunk = (idx_reg == IDXW'(N - 1));

  // Ripple slice; slice_c[CHUNK-1] on the last chunk is the carry into the MSB.
  assign slice_c[0] = carry_reg;
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
    assign slice_sum[gi]  = slice_a[gi] ^ slice_b[gi] ^ slice_c[gi];
    assign slice_c[gi+1]  = (slice_a[gi] & slice_b[gi]) |
                            (slice_c[gi] & (slice_a[gi] ^ slice_b[gi]));
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign s         = s_reg;
  assign cout      = cout_reg;
  assign overflow  = cmsb_reg ^ cout_reg;

  always_comb begin
    state_next = state_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
    s_next     = s_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    cmsb_next  = cmsb_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the forced carry-in supplies the +1.
          state_next = BUSY;
          op_a_next  = a;
          op_b_next  = sub ? ~b : b;
          carry_next = sub ? 1'b1 : cin;
          s_next     = '0;
          cout_next  = 1'b0;
          cmsb_next  = 1'b0;
          idx_next   = '0;
        end
      end
      BUSY: begin
        s_next[base +: CHUNK] = slice_sum;
        carry_next            = slice_c[CHUNK];
        idx_next              = idx_reg + IDXW'(1);
        if (last_chunk) begin
          state_next = DONE;
          cout_next  = slice_c[CHUNK];
          cmsb_next  = slice_c[CHUNK-1];
          idx_next   = '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cmsb_reg  <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
      s_reg     <= s_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      cmsb_reg  <= cmsb_next;
      idx_reg   <= idx_next;
    end
  end

endmodule
